// File: rtl/audio_out_mixer_pkg.sv
// Shared definitions for the voice mixer and the synth side: mixer FSM states,
// width helpers and the sample-rate divider default.
package audio_out_mixer_pkg;

    // 50 MHz / 48 kHz, rounded to the nearest whole clock count
    localparam int DEFAULT_SAMPLE_DIV = 1042;

    typedef enum logic [1:0] {
        MIX_IDLE,
        MIX_ACCUM,
        MIX_SCALE,
        MIX_PUSH
    } mix_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Unsigned voice sample re-centred around zero
    function automatic int centre_offset(input int sample, input int sample_w);
        return sample - (1 << (sample_w - 1));
    endfunction

    // Accumulator width: one centred sample plus headroom for every voice
    function automatic int acc_width(input int sample_w, input int num_voices);
        return sample_w + 1 + clog2(num_voices);
    endfunction

endpackage

// File: rtl/audio_out_mixer_fifo.sv
// Synchronous FIFO holding mixed sample words; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sample_fifo
    import audio_out_mixer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int LVL_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/audio_out_mixer.sv
// Mixes the enabled synth voices once per sample period, scales the sum to a
// codec word, queues it and streams it out through the controller handshake.
module audio_out_mixer
    import audio_out_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 7,
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [4:0]                     gain,
    input  logic                           mute_l,
    input  logic                           mute_r,
    input  logic                           clear_flags,
    input  logic                           audio_out_allowed,
    output logic                           write_audio_out,
    output logic [OUT_W-1:0]               left_channel_audio_out,
    output logic [OUT_W-1:0]               right_channel_audio_out,
    output logic [clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                           overflow
);
    localparam int ACC_W     = acc_width(SAMPLE_W, NUM_VOICES);
    localparam int MAX_SHIFT = OUT_W - ACC_W;
    localparam int IDX_W     = (NUM_VOICES > 1) ? clog2(NUM_VOICES) : 1;
    localparam int DIV_W     = (SAMPLE_DIV > 1) ? clog2(SAMPLE_DIV) : 1;

    // The clamped shift keeps the worst-case sum inside OUT_W, so no saturation
    function automatic logic signed [OUT_W-1:0] scale_word(
        input logic signed [ACC_W-1:0] acc,
        input logic [4:0]              g
    );
        logic signed [OUT_W-1:0] ext;
        int                      sh;
        ext = OUT_W'(acc);
        sh  = (int'(g) > MAX_SHIFT) ? MAX_SHIFT : int'(g);
        return ext <<< sh;
    endfunction

    logic [DIV_W-1:0]               div_cnt;
    logic                           tick;
    mix_state_t                     state;
    logic [IDX_W-1:0]               idx;
    logic [NUM_VOICES*SAMPLE_W-1:0] voice_snap;
    logic [NUM_VOICES-1:0]          en_snap;
    logic signed [ACC_W-1:0]        voice_off;
    logic signed [ACC_W-1:0]        acc_p0;
    logic signed [OUT_W-1:0]        word_p1;
    logic                           fifo_push;
    logic                           fifo_pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [OUT_W-1:0]               fifo_rdata;

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= MIX_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                MIX_IDLE: begin
                    if (tick) begin
                        state <= MIX_ACCUM;
                        idx   <= '0;
                    end
                end
                MIX_ACCUM: begin
                    if (idx == IDX_W'(NUM_VOICES - 1)) state <= MIX_SCALE;
                    else                               idx   <= idx + 1'b1;
                end
                MIX_SCALE: state <= MIX_PUSH;
                MIX_PUSH:  state <= MIX_IDLE;
                default:   state <= MIX_IDLE;
            endcase
        end
    end

    assign voice_off = ACC_W'(centre_offset(int'(voice_snap[idx*SAMPLE_W +: SAMPLE_W]), SAMPLE_W));

    // Stage p0: snapshot and accumulate one voice per cycle
    // Stage p1: scaled word held for the PUSH cycle
    always_ff @(posedge clock) begin
        case (state)
            MIX_IDLE: begin
                if (tick) begin
                    voice_snap <= voice_sample;
                    en_snap    <= voice_en;
                    acc_p0     <= '0;
                end
            end
            MIX_ACCUM: if (en_snap[idx]) acc_p0 <= acc_p0 + voice_off;
            MIX_SCALE: word_p1 <= scale_word(acc_p0, gain);
            default: ;
        endcase
    end

    assign fifo_push = (state == MIX_PUSH);
    // The strobe itself blocks the next pop, limiting drain to one word per two cycles
    assign fifo_pop  = !fifo_empty && audio_out_allowed && !write_audio_out;

    sample_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (word_p1),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_audio_out         <= 1'b0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
            overflow                <= 1'b0;
        end else begin
            write_audio_out <= fifo_pop;
            if (fifo_pop) begin
                left_channel_audio_out  <= mute_l ? '0 : fifo_rdata;
                right_channel_audio_out <= mute_r ? '0 : fifo_rdata;
            end
            if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
            else if (clear_flags)                    overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_out_mixer.sv
// Scoreboard bench for audio_out_mixer with a shortened sample period.
module tb_audio_out_mixer;

    localparam int S = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [27:0] voice_sample = '0;
    logic [3:0]  voice_en = '0;
    logic [4:0]  gain = '0;
    logic        mute_l = 1'b0;
    logic        mute_r = 1'b0;
    logic        clear_flags = 1'b0;
    logic        audio_out_allowed = 1'b0;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic [3:0]  fifo_level;
    logic        overflow;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] exp_l_q[$];
    logic [31:0] exp_r_q[$];

    audio_out_mixer #(
        .NUM_VOICES (4),
        .SAMPLE_W   (7),
        .OUT_W      (32),
        .FIFO_DEPTH (8),
        .SAMPLE_DIV (S)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .voice_sample            (voice_sample),
        .voice_en                (voice_en),
        .gain                    (gain),
        .mute_l                  (mute_l),
        .mute_r                  (mute_r),
        .clear_flags             (clear_flags),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .fifo_level              (fifo_level),
        .overflow                (overflow)
    );

    always #5 clock = ~clock;

    // cyc == k right after the k-th rising edge following reset release
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [31:0] model_word(input logic [27:0] vs, input logic [3:0] en,
                                               input logic [4:0] g);
        int sum;
        int sh;
        sum = 0;
        for (int i = 0; i < 4; i++) if (en[i]) sum += int'(vs[i*7 +: 7]) - 64;
        sh = (g > 5'd22) ? 22 : int'(g);
        return 32'(sum * (1 << sh));
    endfunction

    task automatic set_pattern(input int p);
        for (int i = 0; i < 4; i++) voice_sample[i*7 +: 7] = 7'((p * 13 + i * 29 + 5) % 128);
        voice_en = 4'(p + 1);
        gain     = 5'd2;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Must be called at a falling edge; counts rising edges until the strobe is seen
    task automatic wait_strobe(input int budget, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < budget) begin
            @(posedge clock);
            @(negedge clock);
            waited++;
            if (write_audio_out === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (write_audio_out !== 1'b0) $display("FAIL reset_strobe: got %b expected 0", write_audio_out); else n_pass++;
        n_checks++; if (left_channel_audio_out !== 32'd0) $display("FAIL reset_left: got %h expected 0", left_channel_audio_out); else n_pass++;
        n_checks++; if (right_channel_audio_out !== 32'd0) $display("FAIL reset_right: got %h expected 0", right_channel_audio_out); else n_pass++;
        n_checks++; if (fifo_level !== 4'd0) $display("FAIL reset_level: got %0d expected 0", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_silence();
        bit ok; int waited; int want; logic [31:0] el, er;
        voice_sample = {4{7'd64}}; voice_en = 4'hF; gain = 5'd0;
        mute_l = 1'b0; mute_r = 1'b0; audio_out_allowed = 1'b1;
        exp_l_q.delete(); exp_r_q.delete();
        for (int k = 0; k < 3; k++) begin
            exp_l_q.push_back(model_word(voice_sample, voice_en, gain));
            exp_r_q.push_back(model_word(voice_sample, voice_en, gain));
        end
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            wait_strobe(S + 20, ok, waited);
            want = (k == 0) ? S + 7 : S;
            n_checks++; if (waited !== want) $display("FAIL silence_spacing%0d: got %0d cycles expected %0d", k, waited, want); else n_pass++;
            el = exp_l_q.pop_front(); er = exp_r_q.pop_front();
            n_checks++; if (left_channel_audio_out !== el) $display("FAIL silence_left%0d: got %h expected %h", k, left_channel_audio_out, el); else n_pass++;
            n_checks++; if (right_channel_audio_out !== er) $display("FAIL silence_right%0d: got %h expected %h", k, right_channel_audio_out, er); else n_pass++;
        end
    endtask

    task automatic run_constant(input string name, input int count);
        bit ok; int waited; logic [31:0] el, er;
        apply_reset();
        for (int k = 0; k < count; k++) begin
            wait_strobe(S + 20, ok, waited);
            n_checks++; if (!ok) $display("FAIL %s_strobe%0d: got none after %0d cycles expected one", name, k, waited); else n_pass++;
            el = exp_l_q.pop_front(); er = exp_r_q.pop_front();
            n_checks++; if (left_channel_audio_out !== el) $display("FAIL %s_left%0d: got %h expected %h", name, k, left_channel_audio_out, el); else n_pass++;
            n_checks++; if (right_channel_audio_out !== er) $display("FAIL %s_right%0d: got %h expected %h", name, k, right_channel_audio_out, er); else n_pass++;
        end
    endtask

    task automatic test_single_voice();
        voice_sample = {7'd30, 7'd20, 7'd10, 7'd127}; voice_en = 4'b0001; gain = 5'd3;
        mute_l = 1'b0; mute_r = 1'b1; audio_out_allowed = 1'b1;
        exp_l_q.delete(); exp_r_q.delete();
        for (int k = 0; k < 2; k++) begin exp_l_q.push_back(32'd504); exp_r_q.push_back(32'd0); end
        run_constant("single", 2);
        mute_r = 1'b0;
    endtask

    task automatic test_neg_full_scale();
        voice_sample = '0; voice_en = 4'hF; gain = 5'd31;
        mute_l = 1'b0; mute_r = 1'b0; audio_out_allowed = 1'b1;
        exp_l_q.delete(); exp_r_q.delete();
        for (int k = 0; k < 2; k++) begin exp_l_q.push_back(32'hC000_0000); exp_r_q.push_back(32'hC000_0000); end
        run_constant("negfs", 2);
    endtask

    task automatic test_backpressure();
        int strobes; logic [31:0] el;
        audio_out_allowed = 1'b0; mute_l = 1'b0; mute_r = 1'b0;
        exp_l_q.delete(); exp_r_q.delete();
        set_pattern(0);
        exp_l_q.push_back(model_word(voice_sample, voice_en, gain));
        apply_reset();
        for (int p = 1; p <= 8; p++) begin
            wait_until(p * S);
            set_pattern(p);
            if (p < 8) exp_l_q.push_back(model_word(voice_sample, voice_en, gain));
        end
        wait_until(9 * S + 10);
        n_checks++; if (fifo_level !== 4'd8) $display("FAIL bp_level_full: got %0d expected 8", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL bp_overflow_set: got %b expected 1", overflow); else n_pass++;
        audio_out_allowed = 1'b1;
        strobes = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            if (write_audio_out === 1'b1) begin
                strobes++;
                el = (exp_l_q.size() > 0) ? exp_l_q.pop_front() : 32'hDEAD_BEEF;
                n_checks++; if (left_channel_audio_out !== el) $display("FAIL bp_left%0d: got %h expected %h", strobes, left_channel_audio_out, el); else n_pass++;
                n_checks++; if (right_channel_audio_out !== el) $display("FAIL bp_right%0d: got %h expected %h", strobes, right_channel_audio_out, el); else n_pass++;
            end
        end
        n_checks++; if (strobes !== 8) $display("FAIL bp_drain_count: got %0d expected 8", strobes); else n_pass++;
        n_checks++; if (fifo_level !== 4'd0) $display("FAIL bp_level_empty: got %0d expected 0", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL bp_overflow_sticky: got %b expected 1", overflow); else n_pass++;
        clear_flags = 1'b1;
        @(negedge clock);
        clear_flags = 1'b0;
        n_checks++; if (overflow !== 1'b0) $display("FAIL bp_overflow_clear: got %b expected 0", overflow); else n_pass++;
    endtask

    task automatic test_push_pop_coincide();
        int strobes; logic [31:0] el;
        audio_out_allowed = 1'b0; mute_l = 1'b0; mute_r = 1'b0;
        set_pattern(3);
        exp_l_q.delete(); exp_r_q.delete();
        for (int k = 0; k < 9; k++) exp_l_q.push_back(model_word(voice_sample, voice_en, gain));
        apply_reset();
        wait_until(9 * S + 5);
        n_checks++; if (fifo_level !== 4'd8) $display("FAIL pp_level_before: got %0d expected 8", fifo_level); else n_pass++;
        audio_out_allowed = 1'b1;
        wait_until(9 * S + 6);
        audio_out_allowed = 1'b0;
        @(negedge clock);
        n_checks++; if (write_audio_out !== 1'b1) $display("FAIL pp_strobe: got %b expected 1", write_audio_out); else n_pass++;
        n_checks++; if (fifo_level !== 4'd8) $display("FAIL pp_level_after: got %0d expected 8", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL pp_overflow: got %b expected 0", overflow); else n_pass++;
        el = exp_l_q.pop_front();
        n_checks++; if (left_channel_audio_out !== el) $display("FAIL pp_left: got %h expected %h", left_channel_audio_out, el); else n_pass++;
        audio_out_allowed = 1'b1;
        strobes = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (write_audio_out === 1'b1) begin
                strobes++;
                el = (exp_l_q.size() > 0) ? exp_l_q.pop_front() : 32'hDEAD_BEEF;
                n_checks++; if (left_channel_audio_out !== el) $display("FAIL pp_drain_left%0d: got %h expected %h", strobes, left_channel_audio_out, el); else n_pass++;
            end
        end
        n_checks++; if (strobes !== 8) $display("FAIL pp_drain_count: got %0d expected 8", strobes); else n_pass++;
    endtask

    task automatic test_reset_mid_accum();
        bit ok; int waited; logic [31:0] el;
        audio_out_allowed = 1'b1; mute_l = 1'b0; mute_r = 1'b0;
        set_pattern(5);
        exp_l_q.delete(); exp_r_q.delete();
        for (int k = 0; k < 4; k++) exp_l_q.push_back(model_word(voice_sample, voice_en, gain));
        apply_reset();
        wait_strobe(S + 20, ok, waited);
        audio_out_allowed = 1'b0;
        el = exp_l_q.pop_front();
        n_checks++; if (left_channel_audio_out !== el) $display("FAIL rm_first_left: got %h expected %h", left_channel_audio_out, el); else n_pass++;
        wait_until(5 * S + 1);
        n_checks++; if (fifo_level !== 4'd3) $display("FAIL rm_level_queued: got %0d expected 3", fifo_level); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (write_audio_out !== 1'b0) $display("FAIL rm_strobe: got %b expected 0", write_audio_out); else n_pass++;
        n_checks++; if (left_channel_audio_out !== 32'd0) $display("FAIL rm_left: got %h expected 0", left_channel_audio_out); else n_pass++;
        n_checks++; if (right_channel_audio_out !== 32'd0) $display("FAIL rm_right: got %h expected 0", right_channel_audio_out); else n_pass++;
        n_checks++; if (fifo_level !== 4'd0) $display("FAIL rm_level: got %0d expected 0", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rm_overflow: got %b expected 0", overflow); else n_pass++;
        set_pattern(6);
        exp_l_q.delete();
        exp_l_q.push_back(model_word(voice_sample, voice_en, gain));
        audio_out_allowed = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        wait_strobe(S + 20, ok, waited);
        n_checks++; if (waited !== S + 7) $display("FAIL rm_latency: got %0d cycles expected %0d", waited, S + 7); else n_pass++;
        el = exp_l_q.pop_front();
        n_checks++; if (left_channel_audio_out !== el) $display("FAIL rm_after_left: got %h expected %h", left_channel_audio_out, el); else n_pass++;
        n_checks++; if (right_channel_audio_out !== el) $display("FAIL rm_after_right: got %h expected %h", right_channel_audio_out, el); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #3;
        test_reset();
        test_silence();
        test_single_voice();
        test_neg_full_scale();
        test_backpressure();
        test_push_pop_coincide();
        test_reset_mid_accum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_out_mixer.md
# audio_out_mixer

Parametrised mixing and streaming stage between the synth voice generators and the codec `Audio_Controller`. It samples NUM_VOICES unsigned voice waveforms at a fixed sample rate and sums the enabled ones as signed values. It scales the sum to OUT_W bits and buffers it in a small FIFO. It then drives the controller's write handshake, so the codec receives a real sample stream instead of a statically tied data bus.

## Interface
Parameters:
- NUM_VOICES, 4: number of voice inputs (≥1)
- SAMPLE_W, 7: width of each unsigned voice sample
- OUT_W, 32: width of the codec channel words
- FIFO_DEPTH, 8: sample FIFO entries (power of two, ≥2)
- SAMPLE_DIV, 1042: clock cycles per sample period (50 MHz → ~48 kHz); must be ≥ NUM_VOICES+4

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- voice_sample  in  NUM_VOICES*SAMPLE_W  packed voice samples; voice i is at [i*SAMPLE_W +: SAMPLE_W]
- voice_en  in  NUM_VOICES  per-voice enable
- gain  in  5  left-shift applied to the mixed sum
- mute_l, mute_r  in  1  force that channel word to 0
- clear_flags  in  1  clears the sticky overflow flag
- audio_out_allowed  in  1  codec controller has space
- write_audio_out  out  1  one-cycle write strobe to the controller
- left_channel_audio_out, right_channel_audio_out  out  OUT_W  sample words
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when a mixed sample is dropped

## Operation
- Divider counts 0..SAMPLE_DIV-1 and wraps. `tick` is asserted for one cycle when the count is SAMPLE_DIV-1.
- Mixing FSM states: IDLE, ACCUM, SCALE, PUSH.
  - IDLE: on `tick`, snapshot voice_sample and voice_en, clear the accumulator, set idx=0, go to ACCUM.
  - ACCUM: one voice per cycle. If enabled, add the signed value (sample − 2^(SAMPLE_W−1)), SAMPLE_W+1 bits. After idx=NUM_VOICES−1, go to SCALE.
  - SCALE: compute the sign-extended accumulator shifted left by min(gain, OUT_W−ACC_W), where ACC_W = SAMPLE_W+1+clog2(NUM_VOICES). No saturation is needed because the result always fits in OUT_W. Go to PUSH.
  - PUSH: if the FIFO is not full, write the word. If it is full, drop the word and set overflow. Go to IDLE.
- A `tick` arriving outside IDLE cannot occur, given the SAMPLE_DIV constraint.
- Drain:
  - The pop condition is FIFO non-empty && audio_out_allowed && !write_audio_out.
  - On pop, the registered head word goes to both channel outputs; a muted channel drives 0.
  - write_audio_out is high for exactly the next cycle. A strobe is never asserted on two consecutive cycles.
  - Channel outputs hold their last value between strobes.
- Simultaneous PUSH and pop on the same cycle is legal. fifo_level is unchanged, and a full FIFO accepts the push.
- clear_flags and a new overflow event in the same cycle: overflow stays 1 (set wins).
- Reset, at any time including mid-FSM or mid-strobe:
  - FSM returns to IDLE.
  - Divider, FIFO pointers and fifo_level go to 0.
  - write_audio_out, both channel words and overflow go to 0.
  - Any in-progress accumulation is discarded.

## Timing
- From `tick`, the FIFO write occurs on cycle NUM_VOICES+2 after the tick cycle.
- For an empty FIFO with audio_out_allowed high, the strobe appears 2 cycles after the FIFO write.
- fifo_level updates the cycle after a push or pop.
- Maximum drain rate is one sample per 2 cycles.

## Structure
- The shared package holds:
  - a centre-offset function
  - a clog2 helper
  - the ACC_W derivation
  - the default SAMPLE_DIV constant for 50 MHz/48 kHz, reused by the synth side.
- One sub-module: `sample_fifo`, a synchronous FIFO parametrised in width and depth, with full, empty and level outputs and push/pop permitted in the same cycle.
- The mixing FSM and the drain logic stay in the top level.

## Test plan
- **Mid-scale silence:** all voices enabled at 64 (SAMPLE_W=7), gain=0 → every channel word is 0 and one strobe occurs per SAMPLE_DIV cycles.
- **Single-voice scaling:** voice0=127 only enabled, gain=3 → word = 63<<3 = 504 on both channels. With mute_r=1, the right word is 0.
- **Negative full scale:** 4 voices at 0, gain=31 → gain clamps to OUT_W−ACC_W=22, so word = −256<<22 = 0xC000_0000.
- **Backpressure/overflow:** hold audio_out_allowed=0 for 9 sample periods → fifo_level reaches 8 and overflow=1. After audio_out_allowed rises, 8 strobes occur in 16 cycles, then clear_flags clears overflow.
- **Reset mid-accumulate:** assert reset during ACCUM with 3 entries queued → all outputs 0 immediately. After release, the first strobe carries only samples mixed after reset.
- **Push/pop coincidence:** full FIFO, PUSH on the same cycle as a pop → no overflow and fifo_level stays 8.
